// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: reads a sync-read instruction memory and feeds the
// instruction queue in program order, absorbing back-pressure with an out + skid buffer.
module instr_fetch_unit #(
    parameter int unsigned          PC_W     = 8,
    parameter int unsigned          INSTR_W  = 16,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter logic [3:0]           HALT_OPC = 4'hF
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                cheio,
    output logic                adc,
    output logic [INSTR_W-1:0]  instrOut,
    output logic                imemRd,
    output logic [PC_W-1:0]     imemAddr,
    input  logic [INSTR_W-1:0]  imemData,
    input  logic                redir,
    input  logic [PC_W-1:0]     redirPC,
    output logic [PC_W-1:0]     pc,
    output logic                halted
);

    localparam int unsigned OCC_W = 2;

    logic [PC_W-1:0]    r_pc;
    logic               r_out_v;
    logic [INSTR_W-1:0] r_out_i;
    logic               r_sk_v;
    logic [INSTR_W-1:0] r_sk_i;
    logic               r_infl;
    logic               r_halted;

    logic               w_fire;
    logic [OCC_W-1:0]   w_occ;
    logic [OCC_W-1:0]   w_occ_after;
    logic               w_ret_halt;
    logic               w_issue;
    logic               w_out_v_n;
    logic [INSTR_W-1:0] w_out_i_n;
    logic               w_sk_v_n;
    logic [INSTR_W-1:0] w_sk_i_n;

    // Handshake and issue decision; redirect gates adc so no wrong-path push occurs.
    always_comb begin
        w_fire      = r_out_v & ~cheio & ~redir;
        w_occ       = OCC_W'(r_out_v) + OCC_W'(r_sk_v) + OCC_W'(r_infl);
        w_occ_after = w_occ - OCC_W'(w_fire);
        w_ret_halt  = r_infl & (imemData[INSTR_W-1 -: 4] == HALT_OPC);
        w_issue     = CLR & ~r_halted & ~redir & ~w_ret_halt & (w_occ_after < OCC_W'(2));
    end

    // Buffer movement: the older skid entry advances before the returning word lands.
    always_comb begin
        w_out_v_n = r_out_v & ~w_fire;
        w_out_i_n = r_out_i;
        w_sk_v_n  = r_sk_v;
        w_sk_i_n  = r_sk_i;
        if (r_sk_v && !w_out_v_n) begin
            w_out_v_n = 1'b1;
            w_out_i_n = r_sk_i;
            w_sk_v_n  = 1'b0;
        end
        if (r_infl) begin
            if (!w_out_v_n) begin
                w_out_v_n = 1'b1;
                w_out_i_n = imemData;
            end else begin
                w_sk_v_n  = 1'b1;
                w_sk_i_n  = imemData;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            r_pc     <= RESET_PC;
            r_out_v  <= 1'b0;
            r_out_i  <= '0;
            r_sk_v   <= 1'b0;
            r_sk_i   <= '0;
            r_infl   <= 1'b0;
            r_halted <= 1'b0;
        end else if (redir) begin
            r_pc     <= redirPC;
            r_out_v  <= 1'b0;
            r_sk_v   <= 1'b0;
            r_infl   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_out_v  <= w_out_v_n;
            r_out_i  <= w_out_i_n;
            r_sk_v   <= w_sk_v_n;
            r_sk_i   <= w_sk_i_n;
            r_infl   <= w_issue;
            if (w_issue) begin
                r_pc <= r_pc + PC_W'(1);
            end
            if (w_ret_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign adc      = r_out_v & ~redir;
    assign instrOut = r_out_i;
    assign imemRd   = w_issue;
    assign imemAddr = r_pc;
    assign pc       = r_pc;
    assign halted   = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirect, wrap,
// mid-run reset and HALT, with a second instance started at RESET_PC=8'hFE.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        cheio;
    logic        redir;
    logic [7:0]  redirPC;
    logic        adc;
    logic [15:0] instrOut;
    logic        imemRd;
    logic [7:0]  imemAddr;
    logic [15:0] imemData;
    logic [7:0]  pc;
    logic        halted;

    logic        cheio2  = 1'b0;
    logic        redir2  = 1'b0;
    logic [7:0]  redirPC2 = 8'h00;
    logic        adc2;
    logic [15:0] instrOut2;
    logic        imemRd2;
    logic [7:0]  imemAddr2;
    logic [15:0] imemData2;
    logic [7:0]  pc2;
    logic        halted2;

    logic [15:0] mem [256];
    logic [15:0] push_q [$];
    logic [7:0]  addr_q [$];
    logic [15:0] exp_push [9];
    int          checks = 0;
    int          errors = 0;
    int          base_p;
    int          base_a;
    int          seen3;

    always #5 CLK = ~CLK;

    instr_fetch_unit u_dut (
        .CLK(CLK), .CLR(CLR), .cheio(cheio), .adc(adc), .instrOut(instrOut),
        .imemRd(imemRd), .imemAddr(imemAddr), .imemData(imemData),
        .redir(redir), .redirPC(redirPC), .pc(pc), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE)) u_dut_fe (
        .CLK(CLK), .CLR(CLR), .cheio(cheio2), .adc(adc2), .instrOut(instrOut2),
        .imemRd(imemRd2), .imemAddr(imemAddr2), .imemData(imemData2),
        .redir(redir2), .redirPC(redirPC2), .pc(pc2), .halted(halted2)
    );

    // Sync-read memories and transfer/read logs
    always @(posedge CLK) begin
        if (imemRd)  imemData  <= mem[imemAddr];
        if (imemRd2) imemData2 <= mem[imemAddr2];
        if (adc && !cheio) push_q.push_back(instrOut);
        if (imemRd) addr_q.push_back(imemAddr);
    end

    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'hA000; mem[1] = 16'hA001; mem[2] = 16'hA002; mem[3] = 16'hA003;
        exp_push[0] = 16'hA000; exp_push[1] = 16'hA001; exp_push[2] = 16'hA002;
        exp_push[3] = 16'hA003; exp_push[4] = 16'h1004; exp_push[5] = 16'h1005;
        exp_push[6] = 16'h10FE; exp_push[7] = 16'h10FF; exp_push[8] = 16'hA000;
        imemData = '0; imemData2 = '0;
        CLR = 1'b0; cheio = 1'b0; redir = 1'b0; redirPC = 8'h00;
        nxt(); nxt();
        chk("rst_adc", 32'(adc), 0);
        chk("rst_instr", 32'(instrOut), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_rd", 32'(imemRd), 0);
        chk("rst_pc_fe", 32'(pc2), 'hFE);

        // Streaming from reset
        CLR = 1'b1; #1;
        chk("c0_rd", 32'(imemRd), 1);
        chk("c0_addr", 32'(imemAddr), 0);
        nxt();
        chk("c1_adc", 32'(adc), 0);
        chk("c1_pc", 32'(pc), 1);
        nxt();
        chk("c2_adc", 32'(adc), 1);
        chk("c2_instr", 32'(instrOut), 'hA000);
        chk("c2_pc", 32'(pc), 2);
        chk("fe_c2_instr", 32'(instrOut2), 'h10FE);
        chk("fe_c2_pc", 32'(pc2), 0);
        nxt();
        chk("c3_instr", 32'(instrOut), 'hA001);
        chk("fe_c3_instr", 32'(instrOut2), 'h10FF);
        nxt();
        chk("c4_instr", 32'(instrOut), 'hA002);
        chk("fe_c4_instr", 32'(instrOut2), 'hA000);
        nxt();
        chk("c5_instr", 32'(instrOut), 'hA003);
        chk("c5_pc", 32'(pc), 5);
        chk("fe_c5_instr", 32'(instrOut2), 'hA001);

        // Queue full for five cycles
        cheio = 1'b1; #1;
        chk("full_rd0", 32'(imemRd), 0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            chk("full_adc", 32'(adc), 1);
            chk("full_instr", 32'(instrOut), 'hA003);
            chk("full_rd", 32'(imemRd), 0);
            chk("full_pc", 32'(pc), 5);
        end
        nxt();
        cheio = 1'b0; #1;
        chk("resume_rd", 32'(imemRd), 1);
        chk("resume_addr", 32'(imemAddr), 5);
        nxt();
        chk("resume_sk", 32'(instrOut), 'h1004);
        nxt();
        chk("resume_n1", 32'(instrOut), 'h1005);
        nxt();
        chk("resume_n2", 32'(instrOut), 'h1006);

        // Redirect with out and skid both occupied
        cheio = 1'b1;
        nxt();
        chk("pre_redir_pc", 32'(pc), 8);
        redir = 1'b1; redirPC = 8'h40; #1;
        chk("redir_adc", 32'(adc), 0);
        chk("redir_rd", 32'(imemRd), 0);
        nxt();
        redir = 1'b0; cheio = 1'b0; #1;
        chk("post_redir_adc", 32'(adc), 0);
        chk("post_redir_rd", 32'(imemRd), 1);
        chk("post_redir_addr", 32'(imemAddr), 'h40);
        nxt();
        chk("redir_lat_adc", 32'(adc), 0);
        nxt();
        chk("redir_first", 32'(instrOut), 'h1040);
        chk("redir_first_adc", 32'(adc), 1);

        // Redirect with a read in flight, into the wrap region
        redir = 1'b1; redirPC = 8'hFE; #1;
        chk("redir2_adc", 32'(adc), 0);
        chk("redir2_rd", 32'(imemRd), 0);
        nxt();
        redir = 1'b0; #1;
        chk("redir2_addr", 32'(imemAddr), 'hFE);
        nxt(); nxt();
        chk("wrap_fe", 32'(instrOut), 'h10FE);
        chk("wrap_pc", 32'(pc), 0);
        nxt();
        chk("wrap_ff", 32'(instrOut), 'h10FF);
        nxt();
        chk("wrap_00", 32'(instrOut), 'hA000);
        nxt();
        chk("wrap_01", 32'(instrOut), 'hA001);
        chk("push_count", 32'(push_q.size()), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < push_q.size()) chk($sformatf("push_%0d", i), 32'(push_q[i]), 32'(exp_push[i]));
        end

        // Reset mid-operation with both buffers full, redirect in the same cycle
        cheio = 1'b1;
        nxt();
        chk("pre_rst_instr", 32'(instrOut), 'hA001);
        CLR = 1'b0; redir = 1'b1; redirPC = 8'h55; #1;
        chk("rst_mid_rd", 32'(imemRd), 0);
        nxt();
        CLR = 1'b1; redir = 1'b0; cheio = 1'b0; #1;
        chk("rst_mid_adc", 32'(adc), 0);
        chk("rst_mid_instr", 32'(instrOut), 0);
        chk("rst_mid_pc", 32'(pc), 0);
        chk("rst_mid_addr", 32'(imemAddr), 0);
        nxt();
        chk("rst_mid_lat", 32'(adc), 0);
        nxt();
        chk("rst_mid_first", 32'(instrOut), 'hA000);

        // HALT at address 2
        CLR = 1'b0; mem[2] = 16'hF000;
        nxt();
        base_p = push_q.size(); base_a = addr_q.size();
        CLR = 1'b1;
        nxt(); nxt(); nxt(); nxt();
        chk("halt_instr", 32'(instrOut), 'hF000);
        chk("halt_adc", 32'(adc), 1);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 3);
        chk("halt_rd", 32'(imemRd), 0);
        nxt(); nxt(); nxt(); nxt();
        chk("halt_idle_adc", 32'(adc), 0);
        chk("halt_idle_rd", 32'(imemRd), 0);
        chk("halt_idle_pc", 32'(pc), 3);
        chk("halt_push_count", 32'(push_q.size() - base_p), 3);
        if (push_q.size() >= base_p + 3) begin
            chk("halt_push0", 32'(push_q[base_p]), 'hA000);
            chk("halt_push1", 32'(push_q[base_p+1]), 'hA001);
            chk("halt_push2", 32'(push_q[base_p+2]), 'hF000);
        end
        seen3 = 0;
        for (int i = base_a; i < addr_q.size(); i++) if (addr_q[i] == 8'h03) seen3++;
        chk("halt_no_addr3", 32'(seen3), 0);
        chk("halt_rd_count", 32'(addr_q.size() - base_a), 3);

        // Redirect releases HALT
        redir = 1'b1; redirPC = 8'h10; #1;
        chk("unhalt_redir_rd", 32'(imemRd), 0);
        nxt();
        redir = 1'b0; #1;
        chk("unhalt_flag", 32'(halted), 0);
        chk("unhalt_rd", 32'(imemRd), 1);
        chk("unhalt_addr", 32'(imemAddr), 'h10);
        nxt(); nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
